// File: rtl/serial_cfg_pkg.sv
// serial_cfg_pkg
//   Shared definitions for the serial configuration-chain writer:
//   - 3-bit state encodings for the transmit FSM
//   - default transfer width and SCLK divider
//   - cnt_width(): counter sizing helper ($clog2 with a floor of 1 bit)
package serial_cfg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_HIGH  = 3'd2;
  localparam state_t ST_LOAD  = 3'd3;
  localparam state_t ST_FIN   = 3'd4;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_CLKDIV = 2;

  // Bits needed to index/count n distinct values; never returns 0 so that
  // degenerate parameter values still give a legal vector.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/serial_cfg_phase_timer.sv
// serial_cfg_phase_timer
//   Loadable down-counter that times one SCLK phase. After a load, and for
//   as long as enable stays high, phase_end pulses for one cycle every
//   CLKDIV cycles; the counter reloads itself on each tick.
// Ports:
//   CLK        system clock
//   RESET      asynchronous active-low reset
//   load       restart the phase count (start of a transfer)
//   enable     count while a timed phase is running
//   phase_end  one-cycle tick on the last cycle of a phase
module serial_cfg_phase_timer
  import serial_cfg_pkg::*;
#(
  parameter int CLKDIV = DEFAULT_CLKDIV
) (
  input  logic CLK,
  input  logic RESET,
  input  logic load,
  input  logic enable,
  output logic phase_end
);

  localparam int PW = cnt_width(CLKDIV + 1);
  localparam logic [PW-1:0] RELOAD = PW'(CLKDIV);
  localparam logic [PW-1:0] ONE    = PW'(1);

  logic [PW-1:0] cnt;

  // Count runs CLKDIV..1; reaching 1 marks the final cycle of the phase and
  // the next phase starts from CLKDIV again without any idle cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (enable) begin
      cnt <= (cnt == ONE) ? RELOAD : cnt - ONE;
    end
  end

  assign phase_end = enable && (cnt == ONE);

endmodule

// File: rtl/serial_cfg_tx.sv
// serial_cfg_tx
//   Writes a WIDTH-bit configuration word, MSB first, into an external
//   serial shift chain and then pulses the chain's shadow-load strobe.
//   Every SCLK phase lasts CLKDIV system clocks; SDATA changes together
//   with the SCLK fall so it is stable a full phase around each rise.
// Ports:
//   CLK    system clock
//   RESET  asynchronous active-low reset
//   START  transfer request, sampled while idle
//   DATA   word to send, captured when START is accepted
//   BUSY   transfer in progress
//   DONE   one-cycle completion pulse
//   SCLK   serial clock to the chain (chain captures on rise)
//   SDATA  serial data to the chain
//   SLOAD  shadow-load strobe to the chain
module serial_cfg_tx
  import serial_cfg_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int CLKDIV = DEFAULT_CLKDIV
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic             SCLK,
  output logic             SDATA,
  output logic             SLOAD
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_nxt;

  logic busy_nxt;
  logic done_nxt;
  logic sclk_nxt;
  logic sdata_nxt;
  logic sload_nxt;

  logic accept;
  logic timer_en;
  logic phase_end;

  assign accept   = (state == ST_IDLE) && START;
  assign timer_en = (state == ST_SETUP) || (state == ST_HIGH) || (state == ST_LOAD);

  serial_cfg_phase_timer #(
    .CLKDIV (CLKDIV)
  ) u_timer (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (accept),
    .enable    (timer_en),
    .phase_end (phase_end)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; FIN always lasts exactly one cycle, which is what
  // leaves one IDLE cycle between back-to-back transfers.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (START)     state_nxt = ST_SETUP;
      ST_SETUP: if (phase_end) state_nxt = ST_HIGH;
      ST_HIGH:  if (phase_end) state_nxt = (bit_cnt == '0) ? ST_LOAD : ST_SETUP;
      ST_LOAD:  if (phase_end) state_nxt = ST_FIN;
      ST_FIN:                  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath. The next bit is
  // taken from shift_reg[WIDTH-2] on the SCLK fall so that SDATA updates on
  // the same edge the chain stops looking at it.
  always_comb begin
    busy_nxt  = BUSY;
    done_nxt  = 1'b0;
    sclk_nxt  = SCLK;
    sdata_nxt = SDATA;
    sload_nxt = SLOAD;
    shift_nxt = shift_reg;
    bit_nxt   = bit_cnt;
    case (state)
      ST_IDLE: begin
        if (START) begin
          shift_nxt = DATA;
          sdata_nxt = DATA[WIDTH-1];
          busy_nxt  = 1'b1;
          sclk_nxt  = 1'b0;
          bit_nxt   = LAST_BIT;
        end
      end
      ST_SETUP: begin
        if (phase_end) sclk_nxt = 1'b1;
      end
      ST_HIGH: begin
        if (phase_end) begin
          sclk_nxt = 1'b0;
          if (bit_cnt != '0) begin
            shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
            sdata_nxt = shift_reg[WIDTH-2];
            bit_nxt   = bit_cnt - BW'(1);
          end else begin
            sdata_nxt = 1'b0;
            sload_nxt = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (phase_end) begin
          sload_nxt = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        done_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; a mid-transfer reset drops every strobe
  // at once so the chain never sees SLOAD for a partial word.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      SCLK      <= 1'b0;
      SDATA     <= 1'b0;
      SLOAD     <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      BUSY      <= busy_nxt;
      DONE      <= done_nxt;
      SCLK      <= sclk_nxt;
      SDATA     <= sdata_nxt;
      SLOAD     <= sload_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_nxt;
    end
  end

endmodule

// File: tb/tb_serial_cfg_tx.sv
// tb_serial_cfg_tx
//   Directed bench for serial_cfg_tx. Three instances cover WIDTH=4/CLKDIV=1,
//   WIDTH=8/CLKDIV=3 and WIDTH=8/CLKDIV=1; each drives a behavioural
//   receiving chain (shift flops with async reset plus a shadow register
//   loaded on SLOAD) so the delivered word can be checked.
module tb_serial_cfg_tx;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  always #5 CLK = ~CLK;

  logic       start4,  start8s,  start8f;
  logic [3:0] data4;
  logic [7:0] data8s, data8f;

  logic busy4,  done4,  sclk4,  sdata4,  sload4;
  logic busy8s, done8s, sclk8s, sdata8s, sload8s;
  logic busy8f, done8f, sclk8f, sdata8f, sload8f;

  serial_cfg_tx #(.WIDTH(4), .CLKDIV(1)) u_w4 (
    .CLK(CLK), .RESET(RESET), .START(start4), .DATA(data4),
    .BUSY(busy4), .DONE(done4), .SCLK(sclk4), .SDATA(sdata4), .SLOAD(sload4)
  );

  serial_cfg_tx #(.WIDTH(8), .CLKDIV(3)) u_w8s (
    .CLK(CLK), .RESET(RESET), .START(start8s), .DATA(data8s),
    .BUSY(busy8s), .DONE(done8s), .SCLK(sclk8s), .SDATA(sdata8s), .SLOAD(sload8s)
  );

  serial_cfg_tx #(.WIDTH(8), .CLKDIV(1)) u_w8f (
    .CLK(CLK), .RESET(RESET), .START(start8f), .DATA(data8f),
    .BUSY(busy8f), .DONE(done8f), .SCLK(sclk8f), .SDATA(sdata8f), .SLOAD(sload8f)
  );

  logic [4:0] status4, status8f;
  assign status4  = {busy4,  done4,  sclk4,  sdata4,  sload4};
  assign status8f = {busy8f, done8f, sclk8f, sdata8f, sload8f};

  // Receiving chain models: chain flops reset with RESET, shadow does not.
  logic [3:0] chain4,  shadow4;
  logic [7:0] chain8s, shadow8s;
  logic [7:0] chain8f, shadow8f;
  int rises4 = 0, rises8s = 0, rises8f = 0;
  int sloads4 = 0, sloads8s = 0, sloads8f = 0;
  int dones8s = 0;

  always @(posedge sclk4 or negedge RESET)
    if (!RESET) chain4 <= '0; else chain4 <= {chain4[2:0], sdata4};
  always @(posedge sclk8s or negedge RESET)
    if (!RESET) chain8s <= '0; else chain8s <= {chain8s[6:0], sdata8s};
  always @(posedge sclk8f or negedge RESET)
    if (!RESET) chain8f <= '0; else chain8f <= {chain8f[6:0], sdata8f};

  always @(posedge sload4)  begin shadow4  <= chain4;  sloads4++;  end
  always @(posedge sload8s) begin shadow8s <= chain8s; sloads8s++; end
  always @(posedge sload8f) begin shadow8f <= chain8f; sloads8f++; end

  always @(posedge sclk4)  rises4++;
  always @(posedge sclk8s) rises8s++;
  always @(posedge sclk8f) rises8f++;
  always @(posedge CLK) if (done8s) dones8s++;

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic s4, input logic [3:0] d4,
                                input logic s8s, input logic [7:0] d8s,
                                input logic s8f, input logic [7:0] d8f);
    start4 = s4; data4 = d4;
    start8s = s8s; data8s = d8s;
    start8f = s8f; data8f = d8f;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected {BUSY,DONE,SCLK,SDATA,SLOAD} after E0..E10 for 4'b1011, CLKDIV=1
  logic [4:0] exp_basic [11] = '{
    5'b10010, 5'b10110, 5'b10000, 5'b10100, 5'b10010, 5'b10110,
    5'b10010, 5'b10110, 5'b10001, 5'b01000, 5'b00000
  };

  int base_r, base_s;

  initial begin
    apply_stimulus(1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00);
    $display("[TB] reset and idle");
    #1 RESET = 1'b0;
    #2;
    check_output("reset_status4", 32'(status4), 32'h0);
    check_output("reset_busy8s", 32'(busy8s), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output($sformatf("idle_status4_%0d", i), 32'(status4), 32'h0);
    end
    check_output("idle_no_sclk", 32'(rises4), 32'h0);

    $display("[TB] basic 4-bit word");
    base_r = rises4;
    base_s = sloads4;
    apply_stimulus(1'b1, 4'b1011, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    start4 = 1'b0;
    check_output("basic_e0", 32'(status4), 32'(exp_basic[0]));
    for (int k = 1; k < 11; k++) begin
      tick();
      check_output($sformatf("basic_e%0d", k), 32'(status4), 32'(exp_basic[k]));
    end
    check_output("basic_rises", 32'(rises4 - base_r), 32'd4);
    check_output("basic_sloads", 32'(sloads4 - base_s), 32'd1);
    check_output("basic_shadow", 32'(shadow4), 32'hB);

    $display("[TB] divider timing and ignored start");
    base_r = rises8s;
    base_s = sloads8s;
    apply_stimulus(1'b0, 4'h0, 1'b1, 8'hA5, 1'b0, 8'h00);
    tick();
    start8s = 1'b0;
    check_output("div_e0_busy", 32'(busy8s), 32'h1);
    for (int e = 1; e <= 51; e++) begin
      tick();
      if (e == 3)  check_output("div_e3_sclk", 32'(sclk8s), 32'h1);
      if (e == 6)  check_output("div_e6_sclk_sdata", 32'({sclk8s, sdata8s}), 32'h0);
      if (e == 48) check_output("div_e48_sload", 32'(sload8s), 32'h1);
      if (e == 50) check_output("div_e50_sload_done", 32'({sload8s, done8s}), 32'h2);
      if (e == 51) check_output("div_e51_busy_done_sload", 32'({busy8s, done8s, sload8s}), 32'h2);
      if (e == 9)  begin start8s = 1'b1; data8s = 8'h00; end
      if (e == 10) start8s = 1'b0;
    end
    tick(); tick(); tick();
    check_output("div_idle_after", 32'(busy8s), 32'h0);
    check_output("div_rises", 32'(rises8s - base_r), 32'd8);
    check_output("div_sloads", 32'(sloads8s - base_s), 32'd1);
    check_output("div_dones", 32'(dones8s), 32'd1);
    check_output("div_shadow", 32'(shadow8s), 32'hA5);

    $display("[TB] reset mid-transfer");
    apply_stimulus(1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 8'h5A);
    tick();
    start8f = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    check_output("mid_prior_shadow", 32'(shadow8f), 32'h5A);
    base_s = sloads8f;
    start8f = 1'b1;
    data8f = 8'h3C;
    tick();
    start8f = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_output("mid_e5_busy_sclk", 32'({busy8f, sclk8f}), 32'h3);
    #2 RESET = 1'b0;
    start4 = 1'b1;
    data4 = 4'h3;
    #1;
    check_output("mid_async_drop", 32'(status8f), 32'h0);
    tick();
    @(negedge CLK);
    check_output("mid_held_in_reset", 32'(status8f), 32'h0);
    RESET = 1'b1;

    $display("[TB] start at reset release and back-to-back");
    tick();
    check_output("mid_no_sload", 32'(sloads8f - base_s), 32'd0);
    check_output("mid_shadow_kept", 32'(shadow8f), 32'h5A);
    check_output("b2b_e0", 32'(status4), 32'h10);
    tick();
    data4 = 4'hC;
    for (int i = 2; i <= 9; i++) tick();
    check_output("b2b_e9_done", 32'(done4), 32'h1);
    tick();
    check_output("b2b_e10_fin", 32'({busy4, done4}), 32'h0);
    check_output("b2b_first_shadow", 32'(shadow4), 32'h3);
    tick();
    check_output("b2b_e11_restart", 32'(status4), 32'h12);
    start4 = 1'b0;
    for (int i = 12; i <= 20; i++) tick();
    check_output("b2b_e20_done", 32'(done4), 32'h1);
    tick(); tick();
    check_output("b2b_second_shadow", 32'(shadow4), 32'hC);
    check_output("b2b_idle", 32'(busy4), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
